// File: rtl/cplx_mult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier between NUM_REQ requesters.
// Define CPLX_ARB_TIMEOUT_EN to add the result watchdog (resp_err / mult_sw_rst ports).
module cplx_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 32,
    parameter int RES_W   = 34,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic [NUM_REQ-1:0]      req_val,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [NUM_REQ-1:0]      resp_val,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [RES_W-1:0]        resp_data,
    output logic                    mult_op_val,
    input  logic                    mult_op_ready,
    output logic [OP_W-1:0]         mult_op,
    input  logic                    mult_res_val,
    output logic                    mult_res_ready,
    input  logic [RES_W-1:0]        mult_res,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
`ifdef CPLX_ARB_TIMEOUT_EN
    ,
    output logic                    resp_err,
    output logic                    mult_sw_rst
`endif
);

    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DELIVER  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [OP_W-1:0]     r_op;
    logic [RES_W-1:0]    r_res;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_last_grant;

    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_op_fire;
    logic                w_res_fire;
    logic                w_done;
    logic                w_expire;

    // Rotating priority search: walk from the highest offset down so the
    // requester just after last_grant is the final (winning) assignment.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx    = ID_W'((int'(r_last_grant) + 1 + k) % NUM_REQ);
            w_winner = req_val[w_idx] ? w_idx : w_winner;
            w_any    = w_any | req_val[w_idx];
        end
    end

    // Handshake strobes qualified by the current state.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && w_any;
        w_op_fire  = (r_state == ST_ISSUE) && mult_op_ready;
        w_res_fire = (r_state == ST_WAIT_RES) && mult_res_val;
        w_done     = (r_state == ST_DELIVER) && resp_ready[r_grant];
    end

`ifdef CPLX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_resp_err;
    logic             r_mult_sw_rst;

    // Expiry yields to a result arriving in the same cycle.
    always_comb begin
        w_expire = (r_state == ST_WAIT_RES) && !mult_res_val &&
                   (r_wd_cnt == CNT_W'(TIMEOUT - 1));
    end

    // Watchdog counter, error flag and multiplier reset pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wd_cnt      <= '0;
            r_resp_err    <= 1'b0;
            r_mult_sw_rst <= 1'b0;
        end else if (sw_rst) begin
            r_wd_cnt      <= '0;
            r_resp_err    <= 1'b0;
            r_mult_sw_rst <= 1'b0;
        end else begin
            r_mult_sw_rst <= w_expire;
            if (w_op_fire) begin
                r_wd_cnt <= '0;
            end else if (r_state == ST_WAIT_RES) begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end
            if (w_expire) begin
                r_resp_err <= 1'b1;
            end else if (w_done) begin
                r_resp_err <= 1'b0;
            end
        end
    end

    assign resp_err    = r_resp_err;
    assign mult_sw_rst = r_mult_sw_rst;
`else
    always_comb begin
        w_expire = 1'b0;
    end
`endif

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_op_fire) begin
                    w_next_state = ST_WAIT_RES;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_WAIT_RES: begin
                if (w_res_fire || w_expire) begin
                    w_next_state = ST_DELIVER;
                end else begin
                    w_next_state = ST_WAIT_RES;
                end
            end
            ST_DELIVER: begin
                if (w_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DELIVER;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, operand/result holding registers and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_res        <= '0;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (sw_rst) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_res        <= '0;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op    <= req_op[w_winner*OP_W +: OP_W];
                r_grant <= w_winner;
            end
            if (w_res_fire) begin
                r_res <= mult_res;
            end else if (w_expire) begin
                r_res <= '0;
            end
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Operand accept is the only path that depends on live inputs.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Result valid is one-hot on the registered owner.
    always_comb begin
        resp_val = '0;
        if (r_state == ST_DELIVER) begin
            resp_val[r_grant] = 1'b1;
        end else begin
            resp_val = '0;
        end
    end

    assign resp_data      = r_res;
    assign mult_op        = r_op;
    assign mult_op_val    = (r_state == ST_ISSUE);
    assign mult_res_ready = (r_state == ST_WAIT_RES);
    assign grant_id       = r_grant;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cplx_mult_arbiter.sv
// Directed bench for cplx_mult_arbiter: vector table plus reset/priority/sw_rst sequences.
module tb_cplx_mult_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic         sw_rst;
    logic [3:0]   req_val;
    logic [3:0]   req_ready;
    logic [127:0] req_op;
    logic [3:0]   resp_val;
    logic [3:0]   resp_ready;
    logic [33:0]  resp_data;
    logic         mult_op_val;
    logic         mult_op_ready;
    logic [31:0]  mult_op;
    logic         mult_res_val;
    logic         mult_res_ready;
    logic [33:0]  mult_res;
    logic [1:0]   grant_id;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] ops [4];

    typedef struct {
        int          id;
        logic [31:0] op;
        logic [33:0] exp;
        int          op_stall;
        int          resp_stall;
    } vec_t;

    vec_t tbl [6];

    cplx_mult_arbiter dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
        .req_val(req_val), .req_ready(req_ready), .req_op(req_op),
        .resp_val(resp_val), .resp_ready(resp_ready), .resp_data(resp_data),
        .mult_op_val(mult_op_val), .mult_op_ready(mult_op_ready), .mult_op(mult_op),
        .mult_res_val(mult_res_val), .mult_res_ready(mult_res_ready), .mult_res(mult_res),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [33:0] cmul(input logic [31:0] op);
        logic signed [7:0]  a, b, c, d;
        logic signed [16:0] re, im;
        a  = op[31:24];
        b  = op[23:16];
        c  = op[15:8];
        d  = op[7:0];
        re = 17'(a) * 17'(c) - 17'(b) * 17'(d);
        im = 17'(a) * 17'(d) + 17'(b) * 17'(c);
        return {re, im};
    endfunction

    function automatic logic [3:0] onehot(input int id);
        logic [3:0] v;
        v = 4'b0001 << id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic post(input int id, input logic [31:0] op);
        req_val[id]        = 1'b1;
        req_op[id*32 +: 32] = op;
        ops[id]            = op;
    endtask

    // Full transaction for an already-posted requester; called just after a negedge.
    task automatic serve(input int id, input logic [33:0] exp, input int op_stall, input int resp_stall);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready != 4'b0000) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("grant_wait", 64'd0, 64'd1);
            return;
        end
        chk("req_ready", 64'(req_ready), 64'(onehot(id)));
        @(negedge clk);
        req_val[id] = 1'b0;
        chk("grant_id", 64'(grant_id), 64'(id));
        chk("mult_op_val", 64'(mult_op_val), 64'd1);
        chk("mult_op", 64'(mult_op), 64'(ops[id]));
        for (int s = 0; s < op_stall; s++) begin
            @(negedge clk);
            chk("issue_hold", 64'(mult_op_val), 64'd1);
            chk("issue_no_ready", 64'(req_ready), 64'd0);
        end
        mult_op_ready = 1'b1;
        @(negedge clk);
        mult_op_ready = 1'b0;
        chk("wait_res_ready", 64'(mult_res_ready), 64'd1);
        chk("wait_op_val", 64'(mult_op_val), 64'd0);
        mult_res_val = 1'b1;
        mult_res     = cmul(mult_op);
        @(negedge clk);
        mult_res_val = 1'b0;
        chk("resp_val", 64'(resp_val), 64'(onehot(id)));
        chk("resp_data", 64'(resp_data), 64'(exp));
        resp_ready = ~onehot(id);
        for (int s = 0; s < resp_stall; s++) begin
            @(negedge clk);
            chk("deliver_hold", 64'(resp_val), 64'(onehot(id)));
            chk("deliver_data", 64'(resp_data), 64'(exp));
            chk("deliver_no_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = onehot(id);
        @(negedge clk);
        resp_ready = 4'b0000;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_resp_val", 64'(resp_val), 64'd0);
    endtask

    initial begin
        tbl[0] = '{2, {8'd3, 8'd4, 8'd1, 8'd2},           {17'h1FFFB, 17'd10},   0, 0};
        tbl[1] = '{0, {8'd5, 8'd0, 8'd0, 8'd1},           {17'd0, 17'd5},        0, 0};
        tbl[2] = '{1, {8'hFF, 8'd2, 8'd3, 8'hFE},         {17'd1, 17'd8},        1, 2};
        tbl[3] = '{3, {8'h80, 8'h80, 8'h80, 8'h80},       {17'd0, 17'h08000},    0, 0};
        tbl[4] = '{2, {8'd7, 8'hF9, 8'd2, 8'd3},          {17'd35, 17'd7},       5, 7};
        tbl[5] = '{0, {8'h7F, 8'h7F, 8'h7F, 8'h81},       {17'd32258, 17'd0},    0, 1};

        rstn          = 1'b0;
        sw_rst        = 1'b0;
        req_val       = 4'b0000;
        req_op        = '0;
        resp_ready    = 4'b0000;
        mult_op_ready = 1'b0;
        mult_res_val  = 1'b0;
        mult_res      = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_mult_op", 64'(mult_op), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_mult_sigs", 64'({mult_op_val, mult_res_ready}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            post(tbl[i].id, tbl[i].op);
            serve(tbl[i].id, tbl[i].exp, tbl[i].op_stall, tbl[i].resp_stall);
        end

        // Software reset restores requester 0 as first priority.
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            post(i, {8'(i + 1), 8'd1, 8'd1, 8'd0});
        end
        for (int i = 0; i < 4; i++) begin
            serve(i, {17'(i + 1), 17'd1}, 0, 0);
        end

        // After serving 2, pending 1 and 3 resolve as 3 then 1.
        post(2, {8'd2, 8'd0, 8'd3, 8'd0});
        serve(2, {17'd6, 17'd0}, 0, 0);
        post(1, {8'd0, 8'd1, 8'd0, 8'd1});
        post(3, {8'd1, 8'd1, 8'd1, 8'd1});
        serve(3, {17'd0, 17'd2}, 0, 0);
        serve(1, {17'h1FFFF, 17'd0}, 0, 0);

        // sw_rst while waiting on the multiplier drops the transaction.
        post(1, {8'd9, 8'd9, 8'd9, 8'd9});
        #1;
        chk("swr_req_ready", 64'(req_ready), 64'(onehot(1)));
        @(negedge clk);
        req_val[1]    = 1'b0;
        mult_op_ready = 1'b1;
        @(negedge clk);
        mult_op_ready = 1'b0;
        chk("swr_in_wait", 64'(mult_res_ready), 64'd1);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        chk("swr_busy", 64'(busy), 64'd0);
        chk("swr_resp_val", 64'(resp_val), 64'd0);
        chk("swr_grant_id", 64'(grant_id), 64'd0);
        chk("swr_mult_op", 64'(mult_op), 64'd0);
        chk("swr_res_ready", 64'(mult_res_ready), 64'd0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("swr_quiet", 64'({resp_val, busy}), 64'd0);
        end
        post(3, {8'd2, 8'd0, 8'd0, 8'd2});
        post(0, {8'd1, 8'd0, 8'd1, 8'd0});
        serve(0, {17'd1, 17'd0}, 0, 0);
        serve(3, {17'd0, 17'd4}, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cplx_mult_arbiter.md
Name: cplx_mult_arbiter

Overview:
Round-robin arbiter that shares one complex-number multiplier between NUM_REQ independent requesters. It accepts one operand packet at a time and forwards it over the multiplier's op_val/op_ready handshake. It then collects the result over res_val/res_ready and returns it to the requester that issued it. Only one transaction is in flight at any time, and operand and result data pass through unmodified.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
OP_W, 32, operand packet width {op1_re, op1_im, op2_re, op2_im}, 8 bits each
RES_W, 34, result width {res_re[16:0], res_im[16:0]}
ID_W, 2, grant index width; must equal clog2(NUM_REQ)
TIMEOUT, 64, watchdog limit in cycles (used only with CPLX_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
sw_rst  in  1  synchronous software reset, active 1
req_val  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester operand accept
req_op  in  NUM_REQ*OP_W  packed operands; requester i occupies bits [i*OP_W +: OP_W]
resp_val  out  NUM_REQ  one-hot result valid
resp_ready  in  NUM_REQ  per-requester result accept
resp_data  out  RES_W  shared result bus, qualified by resp_val
mult_op_val  out  1  operand valid to multiplier
mult_op_ready  in  1  multiplier ready for operands
mult_op  out  OP_W  operands to multiplier
mult_res_val  in  1  multiplier result valid
mult_res_ready  out  1  arbiter ready for result
mult_res  in  RES_W  multiplier result
grant_id  out  ID_W  index of the current owner
busy  out  1  high in every state except IDLE
resp_err  out  1  (CPLX_ARB_TIMEOUT_EN only) result is a timeout error
mult_sw_rst  out  1  (CPLX_ARB_TIMEOUT_EN only) reset pulse to multiplier

Behaviour:
- Reset (rstn low or sw_rst high):
  - state = IDLE; op_reg, res_reg and grant_id = 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0.
  - sw_rst is sampled on clk and overrides any state, including mid-transaction. The abandoned transaction is dropped and no resp_val is issued.
- The FSM is fully registered. Outputs are decoded from state and the registered grant.
- IDLE:
  - winner = the first i with req_val[i]=1, searching (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[winner]=1 combinationally; every other req_ready bit is 0.
  - On that same edge: latch req_op[winner] into op_reg, latch grant_id=winner, go to ISSUE.
  - If there is no request, stay in IDLE.
- ISSUE: mult_op_val=1, mult_op=op_reg. On mult_op_ready=1, go to WAIT_RES.
- WAIT_RES: mult_res_ready=1. On mult_res_val=1, latch mult_res into res_reg and go to DELIVER.
- DELIVER:
  - resp_val[grant_id]=1, resp_data=res_reg.
  - On resp_ready[grant_id]=1, set last_grant=grant_id and go to IDLE.
  - A requester that holds resp_ready low stalls the arbiter indefinitely (no timeout in DELIVER).
- Latency, with request accepted at edge T:
  - mult_op_val is high in cycle T+1.
  - resp_val is high 1 cycle after the mult_res handshake edge.
- Minimum request-to-request spacing is 4 cycles plus the multiplier's own latency.
- Protocol rules:
  - A requester holds req_val and req_op stable until req_ready is seen.
  - Requests arriving while busy wait in place; there is no queueing.
  - The arbiter never drops a pending request.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester granted once is lowest priority next round.
- resp_data holds its last value when resp_val is low. mult_op holds op_reg outside ISSUE.

Optional Feature:
CPLX_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_RES and increments each cycle spent there.
  - If it reaches TIMEOUT without mult_res_val, mult_sw_rst pulses high for 1 cycle.
  - The FSM then enters DELIVER with res_reg=0 and resp_err=1.
  - resp_err is cleared on leaving DELIVER.
  - A mult_res_val arriving in the same cycle as expiry takes priority: the result is delivered normally.
- Undefined: no counter, and no resp_err or mult_sw_rst ports. WAIT_RES waits indefinitely.

Test Plan:
- Single request: req_val[2]=1 with req_op={8'd3,8'd4,8'd1,8'd2}; the model multiplier returns re=-5, im=10 -> req_ready[2] pulses 1 cycle, mult_op matches, resp_val=4'b0100, resp_data={17'h1FFFB,17'd10}, grant_id=2.
- All four requesters assert req_val at once from reset -> grants in order 0,1,2,3. Each resp_val is one-hot to the matching requester and carries that requester's result.
- After a grant to 2, requesters 1 and 3 are pending -> 3 is served before 1.
- Backpressure: mult_op_ready held 0 for 5 cycles, then resp_ready held 0 for 7 cycles -> FSM holds in ISSUE, then DELIVER. resp_data is stable throughout and no other req_ready asserts.
- sw_rst asserted in WAIT_RES -> IDLE next cycle, busy=0, no resp_val. Requester 0 then has first priority again.
- With CPLX_ARB_TIMEOUT_EN and TIMEOUT=64, the multiplier never responds -> mult_sw_rst pulses at WAIT_RES cycle 64, then resp_val with resp_err=1 and resp_data=0, then the FSM returns to IDLE.
